// File: rtl/line_pixel_writer.sv
// line_pixel_writer: steps a line through an external stepper and writes every on-screen pixel over req/ack.
// Optional: define LINE_PIXEL_STATS_EN to add the pix_written/pix_clipped counters.
module line_pixel_writer #(
  parameter int FB_WIDTH   = 640,
  parameter int FB_HEIGHT  = 480,
  parameter int ADDR_W     = 20,
  parameter int COLOR_W    = 16,
  parameter int MAX_PIXELS = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        x1,
  input  logic [15:0]        y1,
  input  logic [15:0]        x2,
  input  logic [15:0]        y2,
  input  logic [COLOR_W-1:0] color,
  input  logic [ADDR_W-1:0]  fb_base,
  output logic               calculate,
  output logic               get_pixel,
  output logic [15:0]        sx1,
  output logic [15:0]        sy1,
  output logic [15:0]        sx2,
  output logic [15:0]        sy2,
  input  logic [15:0]        px,
  input  logic [15:0]        py,
  input  logic               line_complete,
  output logic               wr_req,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  input  logic               wr_ack,
  output logic               busy,
  output logic               done,
`ifdef LINE_PIXEL_STATS_EN
  output logic               timeout,
  output logic [15:0]        pix_written,
  output logic [15:0]        pix_clipped
`else
  output logic               timeout
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_LOAD, S_FETCH, S_WRITE, S_STEP, S_SETTLE, S_DONE
  } state_t;

  state_t state, next_state;

  localparam logic [31:0] FB_W32  = 32'(FB_WIDTH);
  localparam logic [31:0] FB_H32  = 32'(FB_HEIGHT);
  localparam logic [15:0] CNT_MAX = 16'(MAX_PIXELS);

  logic [ADDR_W-1:0] base_q;
  logic [15:0]       pix_cnt;
  logic [31:0]       row_offset;
  logic [ADDR_W-1:0] addr_sum;
  logic              clipped;
  logic              cnt_at_max;
  logic              accept;

  // Address arithmetic is done at 32 bits and simply wraps into the ADDR_W window.
  assign row_offset = {16'd0, py} * FB_W32;
  assign addr_sum   = ADDR_W'(row_offset + {16'd0, px} + 32'(base_q));
  assign clipped    = ({16'd0, px} >= FB_W32) || ({16'd0, py} >= FB_H32);
  assign cnt_at_max = (pix_cnt == CNT_MAX);
  assign accept     = (state == S_IDLE) && start;

  assign calculate = (state == S_CALC);
  assign get_pixel = (state == S_STEP);
  assign wr_req    = (state == S_WRITE);
  assign done      = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_CALC;
      S_CALC:   next_state = S_LOAD;
      S_LOAD:   next_state = S_FETCH;
      S_FETCH:  next_state = clipped ? S_STEP : S_WRITE;
      S_WRITE:  if (wr_ack) next_state = S_STEP;
      S_STEP:   next_state = S_SETTLE;
      // line_complete wins over the watchdog so a line ending exactly at the limit is not a timeout.
      S_SETTLE: begin
        if (line_complete)   next_state = S_DONE;
        else if (cnt_at_max) next_state = S_DONE;
        else                 next_state = S_FETCH;
      end
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sx1     <= '0;
      sy1     <= '0;
      sx2     <= '0;
      sy2     <= '0;
      wr_data <= '0;
      wr_addr <= '0;
      base_q  <= '0;
      pix_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      if (accept) begin
        sx1     <= x1;
        sy1     <= y1;
        sx2     <= x2;
        sy2     <= y2;
        wr_data <= color;
        base_q  <= fb_base;
        pix_cnt <= '0;
        timeout <= 1'b0;
      end
      if (state == S_FETCH) wr_addr <= addr_sum;
      if (state == S_STEP && pix_cnt != 16'hFFFF) pix_cnt <= pix_cnt + 16'd1;
      if (state == S_SETTLE && !line_complete && cnt_at_max) timeout <= 1'b1;
    end
  end

`ifdef LINE_PIXEL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_written <= '0;
      pix_clipped <= '0;
    end else if (accept) begin
      pix_written <= '0;
      pix_clipped <= '0;
    end else begin
      if (state == S_WRITE && wr_ack && pix_written != 16'hFFFF)
        pix_written <= pix_written + 16'd1;
      if (state == S_FETCH && clipped && pix_clipped != 16'hFFFF)
        pix_clipped <= pix_clipped + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_line_pixel_writer.sv
// Scoreboard bench for line_pixel_writer: behavioural stepper, ack driver and write monitor feed a queue check.
module tb_line_pixel_writer;

  localparam int ADDR_W  = 20;
  localparam int COLOR_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] data;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [15:0]        x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic [COLOR_W-1:0] color = '0;
  logic [ADDR_W-1:0]  fb_base = '0;
  logic               calculate, get_pixel;
  logic [15:0]        sx1, sy1, sx2, sy2;
  logic [15:0]        px, py;
  logic               line_complete;
  logic               wr_req;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic               wr_ack = 1'b0;
  logic               busy, done, timeout;
`ifdef LINE_PIXEL_STATS_EN
  logic [15:0]        pix_written, pix_clipped;
`endif

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  int gpCount = 0;
  int writesSeen = 0;
  int ackDelay = 0;
  int ackWait = 0;
  logic hangMode = 1'b0;
  logic inReset = 1'b0;
  logic prevWaiting = 1'b0;
  logic [ADDR_W-1:0] prevAddr = '0;
  exp_t expQ[$];

  always #5 clk = ~clk;

  line_pixel_writer #(.MAX_PIXELS(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .color(color), .fb_base(fb_base),
    .calculate(calculate), .get_pixel(get_pixel),
    .sx1(sx1), .sy1(sy1), .sx2(sx2), .sy2(sy2),
    .px(px), .py(py), .line_complete(line_complete),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .busy(busy), .done(done),
`ifdef LINE_PIXEL_STATS_EN
    .timeout(timeout), .pix_written(pix_written), .pix_clipped(pix_clipped)
`else
    .timeout(timeout)
`endif
  );

  // Behavioural stepper: unit steps toward the end point, line_complete on a step taken at the end point.
  logic [15:0] curX = '0, curY = '0;
  logic        lc = 1'b0;
  assign px = curX;
  assign py = curY;
  assign line_complete = lc;

  always @(posedge clk) begin
    if (reset) begin
      curX <= '0; curY <= '0; lc <= 1'b0;
    end else if (calculate) begin
      curX <= sx1; curY <= sy1; lc <= 1'b0;
    end else if (get_pixel) begin
      if (curX == sx2 && curY == sy2) lc <= !hangMode;
      else begin
        if (curX < sx2) curX <= curX + 16'd1;
        else if (curX > sx2) curX <= curX - 16'd1;
        if (curY < sy2) curY <= curY + 16'd1;
        else if (curY > sy2) curY <= curY - 16'd1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Ack driver and write monitor share one negedge process so the ack decision and the pop agree.
  always @(negedge clk) begin
    exp_t e;
    if (prevWaiting && !inReset) begin
      checkOutput("wr_req_held", {31'd0, wr_req}, 32'd1);
      checkOutput("wr_addr_stable", 32'(wr_addr), 32'(prevAddr));
    end
    prevWaiting = 1'b0;
    if (done) doneCount++;
    if (get_pixel) gpCount++;
    if (reset || !wr_req) begin
      wr_ack = 1'b0;
      ackWait = 0;
    end else if (ackWait >= ackDelay) begin
      wr_ack = 1'b1;
      writesSeen++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h, expected no write", wr_addr);
      end else begin
        e = expQ.pop_front();
        checkOutput("wr_addr", 32'(wr_addr), 32'(e.addr));
        checkOutput("wr_data", 32'(wr_data), 32'(e.data));
      end
    end else begin
      ackWait++;
      prevWaiting = 1'b1;
      prevAddr = wr_addr;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic expectWrite(input logic [ADDR_W-1:0] a, input logic [COLOR_W-1:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [15:0] ax1, input logic [15:0] ay1,
                               input logic [15:0] ax2, input logic [15:0] ay2,
                               input logic [COLOR_W-1:0] c, input logic [ADDR_W-1:0] b);
    x1 = ax1; y1 = ay1; x2 = ax2; y2 = ay2; color = c; fb_base = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    checkOutput("calculate_pulse", {31'd0, calculate}, 32'd1);
  endtask

  task automatic waitDone(input int doneBefore, input logic expTimeout);
    int n;
    n = 0;
    while (doneCount == doneBefore && n < 300) begin
      tick();
      n++;
    end
    if (doneCount == doneBefore) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_wait: got no done after %0d cycles, expected a done pulse", n);
    end
    tick();
    checkOutput("busy_after_done", {31'd0, busy}, 32'd0);
    checkOutput("done_low_after", {31'd0, done}, 32'd0);
    repeat (3) tick();
    checkOutput("done_pulses", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("pending_writes", 32'(expQ.size()), 32'd0);
    checkOutput("timeout_flag", {31'd0, timeout}, {31'd0, expTimeout});
    expQ.delete();
  endtask

  initial begin
    int d0, g0, w0, n;
    repeat (3) tick();
    checkOutput("rst_calculate", {31'd0, calculate}, 32'd0);
    checkOutput("rst_get_pixel", {31'd0, get_pixel}, 32'd0);
    checkOutput("rst_wr_req", {31'd0, wr_req}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_timeout", {31'd0, timeout}, 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
    checkOutput("rst_endpoints", {sx1, sy1} | {sx2, sy2}, 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] horizontal line, immediate ack");
    ackDelay = 0;
    for (int i = 0; i < 4; i++) expectWrite(20'h100 + 20'(i), 16'hF800);
    d0 = doneCount; g0 = gpCount;
    applyStimulus(0, 0, 3, 0, 16'hF800, 20'h100);
    waitDone(d0, 1'b0);
    checkOutput("h_get_pixels", 32'(gpCount - g0), 32'd4);

    $display("[TB] vertical line, ack after 3 cycles, stray start ignored");
    ackDelay = 3;
    expectWrite(20'h100 + 20'd1285, 16'h07E0);
    expectWrite(20'h100 + 20'd1925, 16'h07E0);
    expectWrite(20'h100 + 20'd2565, 16'h07E0);
    d0 = doneCount;
    applyStimulus(5, 2, 5, 4, 16'h07E0, 20'h100);
    repeat (6) tick();
    x1 = 99; y1 = 99; x2 = 99; y2 = 99; color = 16'h0000; fb_base = 20'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(d0, 1'b0);

    $display("[TB] x clip at right edge");
    ackDelay = 1;
    expectWrite(20'h2000 + 20'd638, 16'h1234);
    expectWrite(20'h2000 + 20'd639, 16'h1234);
    d0 = doneCount;
    applyStimulus(638, 0, 641, 0, 16'h1234, 20'h2000);
    waitDone(d0, 1'b0);
`ifdef LINE_PIXEL_STATS_EN
    checkOutput("stats_written", 32'(pix_written), 32'd2);
    checkOutput("stats_clipped", 32'(pix_clipped), 32'd2);
`endif

    $display("[TB] y clip at bottom edge");
    ackDelay = 0;
    expectWrite(20'd305920, 16'h5555);
    expectWrite(20'd306560, 16'h5555);
    d0 = doneCount;
    applyStimulus(0, 478, 0, 481, 16'h5555, 20'h0);
    waitDone(d0, 1'b0);

    $display("[TB] address wraps at ADDR_W");
    expectWrite(20'h00000, 16'hAAAA);
    d0 = doneCount;
    applyStimulus(1, 0, 1, 0, 16'hAAAA, 20'hFFFFF);
    waitDone(d0, 1'b0);

    $display("[TB] single point line");
    expectWrite(20'h100 + 20'd4487, 16'h0F0F);
    d0 = doneCount; g0 = gpCount;
    applyStimulus(7, 7, 7, 7, 16'h0F0F, 20'h100);
    waitDone(d0, 1'b0);
    checkOutput("pt_get_pixels", 32'(gpCount - g0), 32'd1);

    $display("[TB] watchdog with stalled stepper");
    hangMode = 1'b1;
    for (int i = 0; i < 8; i++) expectWrite(20'h300 + 20'(i), 16'h7777);
    d0 = doneCount; g0 = gpCount;
    applyStimulus(0, 0, 100, 0, 16'h7777, 20'h300);
    waitDone(d0, 1'b1);
    checkOutput("wd_get_pixels", 32'(gpCount - g0), 32'd8);
    hangMode = 1'b0;
    repeat (4) tick();
    checkOutput("timeout_sticky", {31'd0, timeout}, 32'd1);

    $display("[TB] reset during write of a diagonal");
    ackDelay = 2;
    expectWrite(20'h400, 16'h3C3C);
    expectWrite(20'h400 + 20'd641, 16'h3C3C);
    expectWrite(20'h400 + 20'd1282, 16'h3C3C);
    expectWrite(20'h400 + 20'd1923, 16'h3C3C);
    d0 = doneCount; w0 = writesSeen;
    applyStimulus(0, 0, 3, 3, 16'h3C3C, 20'h400);
    checkOutput("timeout_cleared", {31'd0, timeout}, 32'd0);
    n = 0;
    while (!(writesSeen == w0 + 1 && wr_req) && n < 100) begin
      tick();
      n++;
    end
    checkOutput("second_write_reached", {31'd0, wr_req}, 32'd1);
    inReset = 1'b1;
    reset = 1'b1;
    tick();
    checkOutput("rst_mid_wr_req", {31'd0, wr_req}, 32'd0);
    checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mid_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    checkOutput("rst_no_done", 32'(doneCount - d0), 32'd0);
    expQ.delete();
    inReset = 1'b0;

    $display("[TB] new line after reset");
    ackDelay = 0;
    expectWrite(20'd641, 16'hBEEF);
    expectWrite(20'd1282, 16'hBEEF);
    d0 = doneCount;
    applyStimulus(1, 1, 2, 2, 16'hBEEF, 20'h0);
    waitDone(d0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: got no end of test, expected finish before 300000");
    $fatal(1, "[TB] stuck");
  end

endmodule
